// File: rtl/crc_byte_sequencer_pkg.sv
// Shared types and constants for the CRC byte sequencer.
// Included by crc_byte_sequencer (optional macro CRC_SEQ_BYTE_COUNT_EN).
package crc_byte_sequencer_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_IDX_W     = $clog2(BITS_PER_BYTE);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT =
    BIT_IDX_W'(BITS_PER_BYTE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/crc_byte_sequencer.sv
// Feeds message bytes bit-by-bit into the CRC engine controls.
// Macro CRC_SEQ_BYTE_COUNT_EN adds a saturating byte_count output.
module crc_byte_sequencer
  import crc_byte_sequencer_pkg::*;
#(
  parameter int BYTE_COUNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       crc_initialize,
  output logic       crc_shift,
  output logic [7:0] crc_data,
  output logic [2:0] crc_bit_index,
  output logic       busy,
  output logic       done
`ifdef CRC_SEQ_BYTE_COUNT_EN
  ,
  output logic [BYTE_COUNT_WIDTH-1:0] byte_count
`endif
);

  state_e               state_q, state_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic                 at_last_bit;
  logic                 xfer;

  assign at_last_bit = (bit_q == LAST_BIT);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      WAIT:    in_ready = 1'b1;
      SHIFT:   in_ready = at_last_bit & ~last_q;
      default: in_ready = 1'b0;
    endcase
  end

  // start wins over a coincident transfer
  assign xfer = in_valid & in_ready & ~start;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        state_d = WAIT;
        bit_d   = '0;
      end
      WAIT: begin
        if (xfer) begin
          state_d = SHIFT;
          bit_d   = '0;
          data_d  = in_data;
          last_d  = in_last;
        end
      end
      SHIFT: begin
        bit_d = bit_q + BIT_IDX_W'(1);
        if (at_last_bit) begin
          if (last_q) begin
            state_d = DONE;
          end else if (xfer) begin
            data_d = in_data;
            last_d = in_last;
          end else begin
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (start) state_d = LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign crc_initialize = (state_q == LOAD);
  assign crc_shift      = (state_q == SHIFT);
  assign crc_data       = data_q;
  assign crc_bit_index  = bit_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

`ifdef CRC_SEQ_BYTE_COUNT_EN
  logic [BYTE_COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == LOAD) begin
      count_d = '0;
    end else if (xfer && (count_q != '1)) begin
      count_d = count_q + BYTE_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign byte_count = count_q;
`else
  localparam int unused_bcw = BYTE_COUNT_WIDTH;
`endif

endmodule

// File: doc/crc_byte_sequencer.md
Name: crc_byte_sequencer

Overview:
Upstream feeder for the CRC datapath. Accepts message bytes over a valid/ready stream and drives the CRC engine's initialize, shift, data and bit_index controls: one initialize cycle per message, then eight shift cycles per byte. Signals completion so downstream logic can sample the CRC result.

Parameters:
BYTE_COUNT_WIDTH, 16, width of the optional message byte counter; saturates at all-ones.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a new message and aborts any message in progress
in_valid  input  1  in_data/in_last valid
in_ready  output  1  sequencer accepts a byte this cycle
in_data  input  8  message byte
in_last  input  1  byte is the final byte of the message
crc_initialize  output  1  to CRC engine; load init value
crc_shift  output  1  to CRC engine; shift one bit
crc_data  output  8  to CRC engine; registered current byte, stable for all 8 shifts
crc_bit_index  output  3  to CRC engine; bit select, 0..7
busy  output  1  high from start until done
done  output  1  one-cycle pulse; CRC engine output is final from this cycle on
byte_count  output  BYTE_COUNT_WIDTH  bytes consumed in current/last message (CRC_SEQ_BYTE_COUNT_EN only)

Behaviour:
- Reset: state IDLE; all outputs 0, including crc_data, crc_bit_index, byte_count and the internal last flag.
- Handshake: byte transfers on a rising edge where in_valid & in_ready. in_ready is a function of state and bit counter only, never of in_valid. The upstream source holds in_data/in_last until the transfer.
- States:
  - IDLE: in_ready=0, busy=0. start -> LOAD.
  - LOAD: crc_initialize=1 for exactly one cycle, busy=1 -> WAIT.
  - WAIT: in_ready=1. On transfer, latch in_data into crc_data and in_last into the last flag, clear the bit counter -> SHIFT.
  - SHIFT: crc_shift=1; crc_bit_index equals the bit counter and runs 0,1,...,7 over consecutive cycles.
    - At index 7 with last flag clear, in_ready=1. A transfer then loads the next byte and restarts at index 0 the next cycle, giving back-to-back 8 cycles/byte. With no transfer -> WAIT.
    - At index 7 with last flag set, in_ready=0 -> DONE.
  - DONE: done=1 for one cycle, busy=1 -> IDLE. crc_data is retained.
- Bit ordering: crc_bit_index always ascends. Input reflection is the CRC engine's job, not this block's.
- Latency: transfer at edge t -> first shift in cycle t+1, last shift in t+8. For the final byte, done=1 in cycle t+9.
- start in any state other than IDLE (including the same cycle as a transfer): the transfer is ignored, the message is abandoned and the next state is LOAD. start in DONE also goes to LOAD.
- in_valid in IDLE or LOAD is not accepted (in_ready=0).
- Zero-length messages are unsupported: every message terminates with an in_last byte.
- rst mid-message returns to IDLE next edge; no done pulse.

Optional Feature:
Macro CRC_SEQ_BYTE_COUNT_EN.
- Defined: byte_count is cleared in LOAD, incremented on each transfer, saturates at 2^BYTE_COUNT_WIDTH-1, and holds after DONE until the next start.
- Undefined: the byte_count port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package: the state enum (IDLE, LOAD, WAIT, SHIFT, DONE) and the constant BITS_PER_BYTE=8.
- No sub-module. Top-level integration instantiates this block next to the CRC engine, wiring the crc_* ports directly.

Test Plan:
- CRC-8, poly 0x07, init 0x00, no reflection, xor 0x00; send "123456789" back-to-back -> done once after 9*8 shifts plus setup; CRC = 0xF4; in_ready never high outside WAIT or SHIFT index 7.
- CRC-32, poly 0x04C11DB7, init/xor 0xFFFFFFFF, reflect in/out; same string with random in_valid gaps -> CRC = 0xCBF43926; crc_data stable through each byte's 8 shifts.
- Single byte 0x00, last=1, CRC-8 as in the first scenario -> exactly 8 shift cycles; done in cycle t+9; CRC = 0x00.
- start asserted after 3 bytes of "123456789", then full "123456789" -> abandoned message has no done; final CRC matches the first scenario (0xF4).
- rst pulsed during the SHIFT of byte 2 -> next cycle all outputs 0, state IDLE; a subsequent full message gives the correct CRC.
- CRC_SEQ_BYTE_COUNT_EN defined, BYTE_COUNT_WIDTH=2, 5-byte message -> byte_count goes 1, 2, 3, 3, 3 and holds 3 after done.
